// File: rtl/vga_pattern_mux.sv
// ---------------------------------------------------------------------------
// vga_pattern_mux
//
// Two-stage pipelined pixel source selector. It sits between the video timing
// generator / pong renderer and the output encoder. A mode register and an
// 8-bit frame counter update only at frame start (hcount==0, vcount==0), so
// the picture never tears mid-frame.
//
// Pipeline:
//   stage 1 : registers counts, syncs, blank and the pong pixel. The mode and
//             frame-counter registers also live in this stage, so pixel (0,0)
//             already sees the new mode and count.
//   stage 2 : computes the colour and registers it together with the delayed
//             syncs, blank and the mode in effect.
//   Every output lags its inputs by exactly 2 clocks.
//
// Ports:
//   clk_in        pixel clock
//   rst_in        asynchronous active-high reset
//   sel_in        requested mode, sampled at frame start
//   hcount_in     pixel x
//   vcount_in     pixel y
//   hsync_in      horizontal sync, aligned with the counts
//   vsync_in      vertical sync, aligned with the counts
//   blank_in      1 = outside the active area
//   pong_color_in game pixel, aligned with the counts
//   invert_in     (only with VGA_PATTERN_MUX_INVERT_EN) invert the active
//                 picture for the whole frame, sampled at frame start
//   color_out     final pixel {R,G,B}, R in the MSBs
//   hsync_out     hsync delayed 2 cycles
//   vsync_out     vsync delayed 2 cycles
//   blank_out     blank delayed 2 cycles
//   mode_out      mode of the pixel currently on color_out
//
// Build option:
//   VGA_PATTERN_MUX_INVERT_EN  adds invert_in and the inversion logic.
// ---------------------------------------------------------------------------
module vga_pattern_mux #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int HCOUNT_W    = 11,
    parameter int VCOUNT_W    = 10,
    parameter int COLOR_W     = 4,
    parameter int TILE_LOG2   = 6,
    parameter int SCROLL_STEP = 4,
    parameter int FLASH_LOG2  = 5
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [2:0]             sel_in,
    input  logic [HCOUNT_W-1:0]    hcount_in,
    input  logic [VCOUNT_W-1:0]    vcount_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   blank_in,
    input  logic [3*COLOR_W-1:0]   pong_color_in,
`ifdef VGA_PATTERN_MUX_INVERT_EN
    input  logic                   invert_in,
`endif
    output logic [3*COLOR_W-1:0]   color_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   blank_out,
    output logic [2:0]             mode_out
);

    localparam int PIX_W = 3 * COLOR_W;

    // Expand a 3-bit {R,G,B} code to a full pixel, one bit per channel.
    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] b);
        return {{COLOR_W{b[2]}}, {COLOR_W{b[1]}}, {COLOR_W{b[0]}}};
    endfunction

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic                frame_start;
    logic [HCOUNT_W-1:0] s1_hcount;
    logic [VCOUNT_W-1:0] s1_vcount;
    logic                s1_hsync;
    logic                s1_vsync;
    logic                s1_blank;
    logic [PIX_W-1:0]    s1_pong;
    logic [2:0]          mode_q;
    logic [7:0]          frame_cnt;
    logic                inv_q;

    assign frame_start = (hcount_in == '0) && (vcount_in == '0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_hcount <= '0;
            s1_vcount <= '0;
            s1_hsync  <= 1'b0;
            s1_vsync  <= 1'b0;
            s1_blank  <= 1'b1;
            s1_pong   <= '0;
            mode_q    <= 3'd0;
            frame_cnt <= 8'd0;
        end else begin
            s1_hcount <= hcount_in;
            s1_vcount <= vcount_in;
            s1_hsync  <= hsync_in;
            s1_vsync  <= vsync_in;
            s1_blank  <= blank_in;
            s1_pong   <= pong_color_in;
            // Loading alongside the (0,0) pixel makes the new mode and count
            // visible to that very pixel in stage 2.
            if (frame_start) begin
                mode_q    <= sel_in;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef VGA_PATTERN_MUX_INVERT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            inv_q <= 1'b0;
        end else if (frame_start) begin
            inv_q <= invert_in;
        end
    end
`else
    assign inv_q = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 2: pattern generation
    // ------------------------------------------------------------------
    logic [HCOUNT_W-1:0] scroll_off;
    logic [HCOUNT_W-1:0] h_scroll;
    logic [2:0]          chk_code;
    logic                grid_hit;
    logic [PIX_W-1:0]    pattern;
    logic [PIX_W-1:0]    next_color;

    // Scroll offset wraps with the counter width, just like the sum.
    assign scroll_off = HCOUNT_W'(32'(frame_cnt) * SCROLL_STEP);
    assign h_scroll   = s1_hcount + scroll_off;
    assign chk_code   = s1_hcount[TILE_LOG2+2:TILE_LOG2]
                      + s1_vcount[TILE_LOG2+2:TILE_LOG2];
    assign grid_hit   = (s1_hcount == HCOUNT_W'(0))
                     || (s1_hcount == HCOUNT_W'(H_ACTIVE - 1))
                     || (s1_hcount == HCOUNT_W'(H_ACTIVE / 2))
                     || (s1_vcount == VCOUNT_W'(0))
                     || (s1_vcount == VCOUNT_W'(V_ACTIVE - 1))
                     || (s1_vcount == VCOUNT_W'(V_ACTIVE / 2));

    always_comb begin
        pattern = '0;
        case (mode_q)
            3'd1:    pattern = {PIX_W{grid_hit}};
            3'd2:    pattern = bar_color(s1_hcount[TILE_LOG2+2:TILE_LOG2]);
            3'd3:    pattern = bar_color(chk_code);
            3'd4:    pattern = bar_color(h_scroll[TILE_LOG2+2:TILE_LOG2]);
            3'd5:    pattern = {s1_hcount[HCOUNT_W-2 -: COLOR_W], {(2*COLOR_W){1'b0}}};
            3'd6:    pattern = {PIX_W{frame_cnt[FLASH_LOG2]}};
            default: pattern = s1_pong;   // modes 0 and 7
        endcase

        // Blanking wins over everything, including inversion.
        if (s1_blank) begin
            next_color = '0;
        end else if (inv_q) begin
            next_color = ~pattern;
        end else begin
            next_color = pattern;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            color_out <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b1;
            mode_out  <= 3'd0;
        end else begin
            color_out <= next_color;
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
            blank_out <= s1_blank;
            mode_out  <= mode_q;
        end
    end

endmodule

// File: tb/tb_vga_pattern_mux.sv
// ---------------------------------------------------------------------------
// Testbench for vga_pattern_mux (default parameters).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same
// point, so the pixel driven two puts earlier is the one seen on the outputs.
// ---------------------------------------------------------------------------
module tb_vga_pattern_mux;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [2:0]  sel_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        blank_in;
    logic [11:0] pong_color_in;
    logic        inv_drv;
    logic [11:0] color_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_out;
    logic [2:0]  mode_out;

    int total = 0;
    int bad   = 0;

    // Reference model state: mode, frame count and invert flag in effect.
    int m_mode = 0;
    int m_cnt  = 0;
    int m_inv  = 0;

    // Expected {color, hsync, vsync, blank, mode} per driven pixel.
    logic [17:0] exp_q[$];

    vga_pattern_mux dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .sel_in        (sel_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .blank_in      (blank_in),
        .pong_color_in (pong_color_in),
`ifdef VGA_PATTERN_MUX_INVERT_EN
        .invert_in     (inv_drv),
`endif
        .color_out     (color_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .blank_out     (blank_out),
        .mode_out      (mode_out)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [11:0] bar(int b);
        logic [11:0] c;
        c = 12'h000;
        if ((b / 4) % 2 == 1) c = c | 12'hF00;
        if ((b / 2) % 2 == 1) c = c | 12'h0F0;
        if (b % 2 == 1)       c = c | 12'h00F;
        return c;
    endfunction

    function automatic logic [11:0] ref_color(int h, int v, int mode, int cnt,
                                               int inv, logic bl, logic [11:0] pong);
        logic [11:0] c;
        case (mode)
            1: c = (h == 0 || h == 1023 || h == 512 || v == 0 || v == 767 || v == 384)
                   ? 12'hFFF : 12'h000;
            2: c = bar((h / 64) % 8);
            3: c = bar((h / 64 + v / 64) % 8);
            4: c = bar((((h + cnt * 4) % 2048) / 64) % 8);
            5: c = 12'(((h / 64) % 16) * 256);
            6: c = ((cnt / 32) % 2 == 1) ? 12'hFFF : 12'h000;
            default: c = pong;
        endcase
        if (inv != 0) c = ~c;
        if (bl) c = 12'h000;
        return c;
    endfunction

    // ---------------- driver ----------------
    task automatic put(int h, int v, int sel, logic [11:0] pong,
                       logic hs, logic vs, logic bl, int inv);
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        sel_in        = 3'(sel);
        pong_color_in = pong;
        hsync_in      = hs;
        vsync_in      = vs;
        blank_in      = bl;
        inv_drv       = (inv != 0);
        if (h == 0 && v == 0) begin
            m_mode = sel;
            m_cnt  = (m_cnt + 1) % 256;
`ifdef VGA_PATTERN_MUX_INVERT_EN
            m_inv  = inv;
`else
            m_inv  = 0;
`endif
        end
        exp_q.push_back({ref_color(h, v, m_mode, m_cnt, m_inv, bl, pong),
                         hs, vs, bl, 3'(m_mode)});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_in = 1'b1;
        put(0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        tick();
        total++;
        if ({color_out, hsync_out, vsync_out, blank_out, mode_out} !== {12'h000, 1'b0, 1'b0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL reset_state: got %h want %h",
                     {color_out, hsync_out, vsync_out, blank_out, mode_out},
                     {12'h000, 1'b0, 1'b0, 1'b1, 3'd0});
        end
        rst_in = 1'b0;
        m_mode = 0;
        m_cnt  = 0;
        m_inv  = 0;

        put(5, 5, 3, 12'h123, 1'b1, 1'b0, 1'b0, 0);
        tick();
        put(0, 0, 3, 12'h123, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (mode_out !== 3'd0) begin
            bad++;
            $display("FAIL release_mode_hold: got %0d want 0", mode_out);
        end
        put(64, 0, 3, 12'h123, 1'b1, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (mode_out !== 3'd3 || color_out !== 12'h000) begin
            bad++;
            $display("FAIL mode_at_frame_start: got mode %0d color %h want 3 000", mode_out, color_out);
        end
        put(65, 0, 3, 12'h123, 1'b1, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'h00F || hsync_out !== 1'b1 || blank_out !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_pixel: got %h %b %b want 00f 1 0", color_out, hsync_out, blank_out);
        end

        // Asynchronous reset in the middle of a line.
        #2;
        rst_in = 1'b1;
        #1;
        total++;
        if ({color_out, hsync_out, vsync_out, blank_out, mode_out} !== {12'h000, 1'b0, 1'b0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL async_reset: got %h want %h",
                     {color_out, hsync_out, vsync_out, blank_out, mode_out},
                     {12'h000, 1'b0, 1'b0, 1'b1, 3'd0});
        end
        tick();
        rst_in = 1'b0;
        m_mode = 0;
        m_cnt  = 0;
        m_inv  = 0;
        put(10, 10, 3, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        put(11, 10, 3, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (mode_out !== 3'd0) begin
            bad++;
            $display("FAIL post_reset_mode: got %0d want 0", mode_out);
        end
        put(0, 0, 3, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        put(1, 0, 3, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (mode_out !== 3'd3) begin
            bad++;
            $display("FAIL post_reset_frame_start: got %0d want 3", mode_out);
        end
    endtask

    task automatic test_latency();
        put(0, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        put(100, 50, 0, 12'hABC, 1'b1, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (hsync_out !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: hsync_out got %b want 0", hsync_out);
        end
        put(101, 50, 0, 12'h123, 1'b0, 1'b1, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'hABC || hsync_out !== 1'b1) begin
            bad++;
            $display("FAIL latency_pong: got %h hs %b want abc hs 1", color_out, hsync_out);
        end
        put(102, 50, 0, 12'h456, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'h123 || hsync_out !== 1'b0 || vsync_out !== 1'b1) begin
            bad++;
            $display("FAIL latency_next: got %h hs %b vs %b want 123 0 1", color_out, hsync_out, vsync_out);
        end
    endtask

    task automatic test_mode1();
        int          hh[5] = '{0, 512, 0, 511, 1023};
        int          vv[5] = '{0, 10, 200, 10, 5};
        logic [11:0] ee[5] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF};
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) put(hh[i], vv[i], 1, 12'h5A5, 1'b0, 1'b0, 1'b0, 0);
            else       put(7, 7, 1, 12'h000, 1'b0, 1'b0, 1'b1, 0);
            tick();
            if (i > 0) begin
                total++;
                if (color_out !== ee[i-1]) begin
                    bad++;
                    $display("FAIL mode1_grid(%0d,%0d): got %h want %h", hh[i-1], vv[i-1], color_out, ee[i-1]);
                end
            end
        end
    endtask

    task automatic test_bars();
        int          hh[10] = '{0, 320, 100, 0, 64, 448, 960, 0, 1023, 1152};
        int          vv[10] = '{0, 0, 9, 0, 64, 64, 448, 0, 3, 3};
        int          ss[10] = '{2, 2, 2, 3, 3, 3, 3, 5, 5, 5};
        logic [11:0] ee[10] = '{12'h000, 12'hF0F, 12'h00F, 12'h000, 12'h0F0,
                                12'h000, 12'hFF0, 12'h000, 12'hF00, 12'h200};
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) put(hh[i], vv[i], ss[i], 12'h5A5, 1'b0, 1'b0, 1'b0, 0);
            else        put(7, 7, 5, 12'h000, 1'b0, 1'b0, 1'b1, 0);
            tick();
            if (i > 0) begin
                total++;
                if (color_out !== ee[i-1] || mode_out !== 3'(ss[i-1])) begin
                    bad++;
                    $display("FAIL bars_mode%0d(%0d,%0d): got %h mode %0d want %h", ss[i-1],
                             hh[i-1], vv[i-1], color_out, mode_out, ee[i-1]);
                end
            end
        end
    endtask

    task automatic test_scroll();
        int guard;
        guard = 0;
        while (m_cnt != 15 && guard < 300) begin
            put(0, 0, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);
            tick();
            guard++;
        end
        put(0, 0, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);   // count becomes 16
        tick();
        put(1, 1, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'h00F) begin
            bad++;
            $display("FAIL scroll_cnt16: got %h want 00f", color_out);
        end
        put(2, 1, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'h00F) begin
            bad++;
            $display("FAIL scroll_cnt16_h1: got %h want 00f", color_out);
        end
        guard = 0;
        while (m_cnt != 254 && guard < 300) begin
            put(0, 0, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);
            tick();
            guard++;
        end
        put(0, 0, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);   // count 255, h' = 1020
        tick();
        put(0, 0, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);   // count wraps to 0
        tick();
        total++;
        if (color_out !== 12'hFFF) begin
            bad++;
            $display("FAIL scroll_cnt255: got %h want fff", color_out);
        end
        put(64, 3, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'h000) begin
            bad++;
            $display("FAIL scroll_wrap0: got %h want 000", color_out);
        end
        put(65, 3, 4, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'h00F) begin
            bad++;
            $display("FAIL scroll_wrap_h64: got %h want 00f", color_out);
        end
    endtask

    task automatic test_sel_hold();
        int          hh[6] = '{0, 5, 6, 700, 0, 3};
        int          ss[6] = '{1, 2, 2, 2, 2, 1};
        logic [2:0]  ee[6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) put(hh[i], (hh[i] == 0) ? 0 : 5, ss[i], 12'h000, 1'b0, 1'b0, 1'b0, 0);
            else       put(9, 9, 1, 12'h000, 1'b0, 1'b0, 1'b0, 0);
            tick();
            if (i > 0) begin
                total++;
                if (mode_out !== ee[i-1]) begin
                    bad++;
                    $display("FAIL sel_hold_%0d: got %0d want %0d", i - 1, mode_out, ee[i-1]);
                end
            end
        end
    endtask

    task automatic test_flash_blank();
        int guard;
        guard = 0;
        while (m_cnt != 39 && guard < 300) begin
            put(0, 0, 6, 12'h000, 1'b0, 1'b0, 1'b0, 0);
            tick();
            guard++;
        end
        put(0, 0, 6, 12'h000, 1'b0, 1'b0, 1'b0, 0);   // count 40: flash on
        tick();
        put(10, 10, 6, 12'hABC, 1'b0, 1'b0, 1'b1, 0);
        tick();
        total++;
        if (color_out !== 12'hFFF) begin
            bad++;
            $display("FAIL flash_on: got %h want fff", color_out);
        end
        put(11, 10, 6, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'h000 || blank_out !== 1'b1) begin
            bad++;
            $display("FAIL flash_blanked: got %h blank %b want 000 1", color_out, blank_out);
        end
        put(12, 10, 6, 12'h000, 1'b0, 1'b0, 1'b0, 0);
        tick();
        total++;
        if (color_out !== 12'hFFF || blank_out !== 1'b0) begin
            bad++;
            $display("FAIL flash_unblank: got %h blank %b want fff 0", color_out, blank_out);
        end
    endtask

    task automatic test_random();
        logic [17:0] e;
        logic [17:0] obs;
        int h;
        int v;
        exp_q.delete();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                h = 0;
                v = 0;
            end else begin
                h = int'($urandom_range(0, 2047));
                v = int'($urandom_range(0, 1023));
            end
            put(h, v, int'($urandom_range(0, 7)), 12'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)));
            tick();
            if (exp_q.size() == 2) begin
                e   = exp_q.pop_front();
                obs = {color_out, hsync_out, vsync_out, blank_out, mode_out};
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL random_%0d: got %h want %h", n, obs, e);
                end
            end
        end
    endtask

    initial begin
        rst_in        = 1'b1;
        sel_in        = 3'd0;
        hcount_in     = '0;
        vcount_in     = '0;
        hsync_in      = 1'b0;
        vsync_in      = 1'b0;
        blank_in      = 1'b1;
        pong_color_in = '0;
        inv_drv       = 1'b0;
        test_reset();
        test_latency();
        test_mode1();
        test_bars();
        test_scroll();
        test_sel_hold();
        test_flash_blank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
